// File: rtl/ddr_ail_if.sv
// Handshake bundle between bring-up logic, the AIL sequencer and one DDR input cell.
interface ddr_ail_if;
    logic       START;
    logic       LOCK_IN;
    logic       RSTAIL_OUT;
    logic       RUNAIL_OUT;
    logic       UPDATE_OUT;
    logic       BUSY;
    logic       LOCKED;
    logic       FAIL;
    logic [3:0] RETRY_CNT;

    // Bring-up / DDR-cell side: drives START and LOCK_IN, observes the controls.
    modport master (
        output START, LOCK_IN,
        input  RSTAIL_OUT, RUNAIL_OUT, UPDATE_OUT, BUSY, LOCKED, FAIL, RETRY_CNT
    );

    // Sequencer side.
    modport slave (
        input  START, LOCK_IN,
        output RSTAIL_OUT, RUNAIL_OUT, UPDATE_OUT, BUSY, LOCKED, FAIL, RETRY_CNT
    );
endinterface

// File: rtl/ddr_ail_ctrl.sv
// AIL acquisition sequencer: reset pulse, timed run window, bounded retries,
// automatic re-acquisition on loss of lock. All outputs come straight from flops.
module ddr_ail_ctrl #(
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 64,
    parameter int MAX_RETRY    = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic     CLKB,
    input  logic     RSTAILB,
    ddr_ail_if.slave bus
);

    localparam int TMAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] RUN_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    state_e                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3:0]             retry_q, retry_d;
    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic                   rstail_q, rstail_d;
    logic                   runail_q, runail_d;
    logic                   update_q, update_d;
    logic                   busy_q,   busy_d;
    logic                   locked_q, locked_d;
    logic                   fail_q,   fail_d;
    logic                   lock_s;

    // Shift LOCK_IN through the synchronizer chain; the last stage is lock_s.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.LOCK_IN};
        lock_s = sync_q[SYNC_STAGES-1];
    end

    // Next-state, timer and retry bookkeeping.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        update_d = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (bus.START) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            ST_RESET: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock takes priority over a timeout on the same cycle.
                if (lock_s) begin
                    state_d  = ST_LOCKED;
                    timer_d  = '0;
                    update_d = 1'b1;
                end else if (timer_q == RUN_LAST) begin
                    timer_d = '0;
                    retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + 4'd1;
                    state_d = (retry_d == RETRY_MAX) ? ST_FAIL : ST_RESET;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                // Loss of lock starts a fresh acquisition with a clean retry budget.
                if (!lock_s) begin
                    state_d = ST_RESET;
                    timer_d = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                retry_d = '0;
            end
        endcase
    end

    // Decode the outputs from the next state so they are registered alongside it.
    always_comb begin
        rstail_d = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAIL);
        runail_d = (state_d == ST_RUN);
        busy_d   = (state_d == ST_RESET) || (state_d == ST_RUN);
        locked_d = (state_d == ST_LOCKED);
        fail_d   = (state_d == ST_FAIL);
    end

    // State, counters, synchronizer and output flops; reset forces the idle outputs at once.
    always_ff @(posedge CLKB or posedge RSTAILB) begin
        if (RSTAILB) begin
            // NOTE: every flop here is small control state, so all of them take the async reset.
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            retry_q  <= '0;
            sync_q   <= '0;
            rstail_q <= 1'b1;
            runail_q <= 1'b0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            sync_q   <= sync_d;
            rstail_q <= rstail_d;
            runail_q <= runail_d;
            update_q <= update_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            fail_q   <= fail_d;
        end
    end

    assign bus.RSTAIL_OUT = rstail_q;
    assign bus.RUNAIL_OUT = runail_q;
    assign bus.UPDATE_OUT = update_q;
    assign bus.BUSY       = busy_q;
    assign bus.LOCKED     = locked_q;
    assign bus.FAIL       = fail_q;
    assign bus.RETRY_CNT  = retry_q;

endmodule

// File: tb/tb_ddr_ail_ctrl.sv
// Bench for ddr_ail_ctrl: directed scenarios followed by randomized START/LOCK_IN
// traffic, all checked every cycle against a phase-level reference model.
module tb_ddr_ail_ctrl;

    localparam int RC = 4;
    localparam int LT = 64;
    localparam int MR = 3;
    localparam int SS = 2;

    localparam int PH_IDLE   = 0;
    localparam int PH_RESET  = 1;
    localparam int PH_RUN    = 2;
    localparam int PH_LOCKED = 3;
    localparam int PH_FAIL   = 4;

    localparam int SIG_RSTAIL = 0;
    localparam int SIG_RUNAIL = 1;
    localparam int SIG_UPDATE = 2;
    localparam int SIG_LOCKED = 3;
    localparam int SIG_FAIL   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    ddr_ail_if bus ();

    ddr_ail_ctrl #(
        .RST_CYCLES  (RC),
        .LOCK_TIMEOUT(LT),
        .MAX_RETRY   (MR),
        .SYNC_STAGES (SS)
    ) dut (
        .CLKB   (clk),
        .RSTAILB(rst),
        .bus    (bus)
    );

    // Reference model: current phase, cycles spent in it, failed attempts,
    // and the LOCK_IN samples still travelling through the synchronizer.
    int ph;
    int cnt;
    int rtr;
    bit upd;
    bit hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ph  = PH_IDLE;
        cnt = 0;
        rtr = 0;
        upd = 0;
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(1'b0);
    endfunction

    function automatic void model_step(input bit st, input bit lk);
        bit seen;
        seen = hist.pop_front();
        hist.push_back(lk);
        upd = 0;
        case (ph)
            PH_IDLE, PH_FAIL: if (st) begin ph = PH_RESET; cnt = 0; rtr = 0; end
            PH_RESET: begin
                if (cnt == RC - 1) begin ph = PH_RUN; cnt = 0; end
                else cnt++;
            end
            PH_RUN: begin
                if (seen) begin
                    ph = PH_LOCKED; cnt = 0; upd = 1;
                end else if (cnt == LT - 1) begin
                    rtr++;
                    cnt = 0;
                    ph = (rtr == MR) ? PH_FAIL : PH_RESET;
                end else begin
                    cnt++;
                end
            end
            PH_LOCKED: if (!seen) begin ph = PH_RESET; cnt = 0; rtr = 0; end
            default: ph = PH_IDLE;
        endcase
    endfunction

    task automatic compare_all();
        check("rstail", bus.RSTAIL_OUT, (ph == PH_IDLE || ph == PH_RESET || ph == PH_FAIL));
        check("runail", bus.RUNAIL_OUT, (ph == PH_RUN));
        check("update", bus.UPDATE_OUT, upd);
        check("busy",   bus.BUSY,       (ph == PH_RESET || ph == PH_RUN));
        check("locked", bus.LOCKED,     (ph == PH_LOCKED));
        check("fail",   bus.FAIL,       (ph == PH_FAIL));
        check("retry",  bus.RETRY_CNT,  rtr);
    endtask

    // One clock: model advances on the rising edge, DUT is checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step(bus.START, bus.LOCK_IN);
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            SIG_RSTAIL: return bus.RSTAIL_OUT;
            SIG_RUNAIL: return bus.RUNAIL_OUT;
            SIG_UPDATE: return bus.UPDATE_OUT;
            SIG_LOCKED: return bus.LOCKED;
            default:    return bus.FAIL;
        endcase
    endfunction

    // Tick until the chosen output reaches val; the tick count must equal exp_n.
    task automatic run_until(input string tag, input int sel, input logic val, input int exp_n);
        int n;
        bit hit;
        n   = 0;
        hit = 0;
        while (!hit && n < exp_n + 20) begin
            tick();
            n++;
            if (get_sig(sel) === val) hit = 1;
        end
        check(tag, n, exp_n);
    endtask

    initial begin
        int hold;
        bit reached;

        bus.START   = 1'b0;
        bus.LOCK_IN = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Asynchronous reset in the middle of a run window.
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        run_until("start_to_run", SIG_RUNAIL, 1'b1, RC);
        repeat (5) tick();
        apply_reset();
        check("rst_runail", bus.RUNAIL_OUT, 1'b0);
        check("rst_rstail", bus.RSTAIL_OUT, 1'b1);

        // Normal acquisition and one-cycle UPDATE.
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        check("start_busy", bus.BUSY, 1'b1);
        run_until("start_to_run2", SIG_RUNAIL, 1'b1, RC);
        repeat (10) tick();
        bus.LOCK_IN = 1'b1;
        run_until("lock_to_update", SIG_UPDATE, 1'b1, SS + 1);
        tick();
        check("update_once", bus.UPDATE_OUT, 1'b0);

        // Loss of lock, then a second acquisition with a second UPDATE.
        bus.LOCK_IN = 1'b0;
        run_until("loss_to_rstail", SIG_RSTAIL, 1'b1, SS + 1);
        run_until("reacq_run", SIG_RUNAIL, 1'b1, RC);
        bus.LOCK_IN = 1'b1;
        run_until("second_update", SIG_UPDATE, 1'b1, SS + 1);

        // Timeout path: three full run windows then FAIL.
        bus.LOCK_IN = 1'b0;
        run_until("loss2_to_rstail", SIG_RSTAIL, 1'b1, SS + 1);
        run_until("reset_len0", SIG_RUNAIL, 1'b1, RC);
        for (int w = 1; w <= MR; w++) begin
            run_until("run_len", SIG_RUNAIL, 1'b0, LT);
            check("retry_step", bus.RETRY_CNT, w);
            if (w < MR) run_until("reset_len", SIG_RUNAIL, 1'b1, RC);
        end
        check("fail_set", bus.FAIL, 1'b1);
        repeat (5) tick();
        check("fail_sticky", bus.FAIL, 1'b1);
        check("fail_retry", bus.RETRY_CNT, MR);

        // Restart from FAIL with START held high: no re-trigger.
        bus.START = 1'b1;
        tick();
        check("restart_retry", bus.RETRY_CNT, 0);
        check("restart_busy", bus.BUSY, 1'b1);
        repeat (10) tick();
        bus.START = 1'b0;

        // Lock seen exactly on the final cycle of the run window.
        reached = 0;
        for (int i = 0; i < 300 && !reached; i++) begin
            if (ph == PH_RUN && cnt == LT - 3) reached = 1;
            else tick();
        end
        check("reach_edge", reached, 1'b1);
        bus.LOCK_IN = 1'b1;
        repeat (3) tick();
        check("edge_locked", bus.LOCKED, 1'b1);
        check("edge_retry", bus.RETRY_CNT, 0);

        // START is ignored in LOCKED and in RUN (timer keeps its count).
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        repeat (3) tick();
        check("ign_locked", bus.LOCKED, 1'b1);
        bus.LOCK_IN = 1'b0;
        run_until("loss3_to_rstail", SIG_RSTAIL, 1'b1, SS + 1);
        run_until("reset_len3", SIG_RUNAIL, 1'b1, RC);
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        run_until("ign_run_len", SIG_RUNAIL, 1'b0, LT - 1);

        // Randomized traffic with occasional asynchronous resets.
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end else begin
                bus.START = ($urandom_range(0, 19) == 0);
                if (hold == 0) begin
                    bus.LOCK_IN = ($urandom_range(0, 2) != 0);
                    hold = $urandom_range(1, 120);
                end else begin
                    hold--;
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
